// File: rtl/produce_spawner.sv
// Paced spawn-request generator: turns the LFSR byte stream into x/type/speed offers, capped by live-object count.
// Optional macro SPAWN_DIFFICULTY_EN adds the level port that shortens the reload gap.
module produce_spawner #(
    parameter int X_MIN      = 64,
    parameter int MIN_GAP    = 16,
    parameter int GAP_BITS   = 6,
    parameter int MAX_ACTIVE = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       frame_tick,
    input  logic [7:0] rand_in,
`ifdef SPAWN_DIFFICULTY_EN
    input  logic [1:0] level,
`endif
    output logic       spawn_valid,
    input  logic       spawn_ready,
    output logic [9:0] spawn_x,
    output logic [1:0] spawn_type,
    output logic [2:0] spawn_vel,
    output logic [2:0] active_count,
    input  logic       despawn
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RELOAD,
        S_WAIT,
        S_PICK_X,
        S_PICK_TV,
        S_OFFER
    } state_t;

    localparam logic [2:0] L_MAX   = 3'(MAX_ACTIVE);
    localparam logic [9:0] L_X_MIN = 10'(X_MIN);

    state_t      r_state;
    logic [15:0] r_gap_cnt;
    logic        r_valid;
    logic [9:0]  r_x;
    logic [1:0]  r_type;
    logic [2:0]  r_vel;
    logic [2:0]  r_count;

    logic [15:0] w_gap_load;
    logic        w_accept;
    logic        w_despawn_ok;

    always_comb begin
        w_gap_load = '0;
`ifdef SPAWN_DIFFICULTY_EN
        w_gap_load = 16'(MIN_GAP >> level) + 16'(rand_in[GAP_BITS-1:0] >> level);
`else
        w_gap_load = 16'(MIN_GAP) + 16'(rand_in[GAP_BITS-1:0]);
`endif
    end

    // The count follows the handshake itself, so the consumer and this block always agree.
    assign w_accept     = r_valid & spawn_ready;
    assign w_despawn_ok = despawn & (r_count != 3'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_gap_cnt <= '0;
            r_valid   <= 1'b0;
            r_x       <= '0;
            r_type    <= '0;
            r_vel     <= '0;
            r_count   <= '0;
        end else begin
            if (w_accept && !w_despawn_ok && (r_count < L_MAX))
                r_count <= r_count + 3'd1;
            else if (!w_accept && w_despawn_ok)
                r_count <= r_count - 3'd1;

            if (!enable) begin
                r_state   <= S_IDLE;
                r_valid   <= 1'b0;
                r_gap_cnt <= '0;
            end else begin
                case (r_state)
                    S_IDLE: r_state <= S_RELOAD;
                    S_RELOAD: begin
                        r_gap_cnt <= w_gap_load;
                        r_state   <= S_WAIT;
                    end
                    S_WAIT: begin
                        if (r_gap_cnt == 16'd0) begin
                            if (r_count < L_MAX)
                                r_state <= S_PICK_X;
                        end else if (frame_tick) begin
                            r_gap_cnt <= r_gap_cnt - 16'd1;
                        end
                    end
                    S_PICK_X: begin
                        r_x     <= L_X_MIN + {1'b0, rand_in, 1'b0};
                        r_state <= S_PICK_TV;
                    end
                    S_PICK_TV: begin
                        r_type  <= rand_in[1:0];
                        r_vel   <= 3'd4 + {1'b0, rand_in[3:2]};
                        r_valid <= 1'b1;
                        r_state <= S_OFFER;
                    end
                    S_OFFER: begin
                        if (spawn_ready) begin
                            r_valid <= 1'b0;
                            r_state <= S_RELOAD;
                        end
                    end
                    default: begin
                        r_valid <= 1'b0;
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign spawn_valid  = r_valid;
    assign spawn_x      = r_x;
    assign spawn_type   = r_type;
    assign spawn_vel    = r_vel;
    assign active_count = r_count;

endmodule

// File: tb/tb_produce_spawner.sv
// Directed bench for produce_spawner: spawn timing, backpressure, capacity, count edge cases, async reset.
module tb_produce_spawner;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       frame_tick = 1'b0;
    logic [7:0] rand_in = 8'h00;
    logic       spawn_valid;
    logic       spawn_ready = 1'b0;
    logic [9:0] spawn_x;
    logic [1:0] spawn_type;
    logic [2:0] spawn_vel;
    logic [2:0] active_count;
    logic       despawn = 1'b0;
`ifdef SPAWN_DIFFICULTY_EN
    logic [1:0] level = 2'd0;
`endif

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    produce_spawner #(
        .X_MIN(64), .MIN_GAP(16), .GAP_BITS(6), .MAX_ACTIVE(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .frame_tick(frame_tick),
        .rand_in(rand_in),
`ifdef SPAWN_DIFFICULTY_EN
        .level(level),
`endif
        .spawn_valid(spawn_valid),
        .spawn_ready(spawn_ready),
        .spawn_x(spawn_x),
        .spawn_type(spawn_type),
        .spawn_vel(spawn_vel),
        .active_count(active_count),
        .despawn(despawn)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock with optional frame tick / despawn pulse; samples 1 time unit after the edge.
    task automatic cyc(input logic tk, input logic dsp);
        frame_tick = tk;
        despawn    = dsp;
        @(posedge clk);
        #1;
        frame_tick = 1'b0;
        despawn    = 1'b0;
    endtask

    task automatic run_to_valid(input int unsigned limit, input string tag);
        int unsigned n;
        n = 0;
        while (!spawn_valid && n < limit) begin
            cyc(1'b1, 1'b0);
            n++;
        end
        chk(tag, 32'(spawn_valid), 32'd1);
    endtask

    initial begin
        logic [9:0]  hold_x;
        logic [1:0]  hold_t;
        logic [2:0]  hold_v;
        int unsigned n_acc;

        // Reset state
        #1;
        chk("rst_valid", 32'(spawn_valid), 32'd0);
        chk("rst_x",     32'(spawn_x),     32'd0);
        chk("rst_count", 32'(active_count), 32'd0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;

        // Spawn: gap 16+5=21, tick every 4 clk
        enable  = 1'b1;
        rand_in = 8'h05;
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        for (int t = 1; t <= 21; t++) begin
            cyc(1'b0, 1'b0); cyc(1'b0, 1'b0); cyc(1'b0, 1'b0); cyc(1'b1, 1'b0);
            if (t == 20) chk("gap_tick20_valid", 32'(spawn_valid), 32'd0);
        end
        chk("gap0_valid", 32'(spawn_valid), 32'd0);
        cyc(1'b0, 1'b0);
        chk("lat1_valid", 32'(spawn_valid), 32'd0);
        cyc(1'b0, 1'b0);
        chk("lat2_valid", 32'(spawn_valid), 32'd0);
        cyc(1'b0, 1'b0);
        chk("lat3_valid", 32'(spawn_valid), 32'd1);
        chk("spawn_x",    32'(spawn_x),    32'd74);
        chk("spawn_type", 32'(spawn_type), 32'd1);
        chk("spawn_vel",  32'(spawn_vel),  32'd5);

        // Backpressure: fields and valid hold while rand_in churns
        hold_x = spawn_x; hold_t = spawn_type; hold_v = spawn_vel;
        for (int i = 0; i < 10; i++) begin
            rand_in = 8'(i * 37 + 200);
            cyc(1'b1, 1'b0);
            chk("bp_valid", 32'(spawn_valid), 32'd1);
            chk("bp_x",     32'(spawn_x),    32'(hold_x));
            chk("bp_type",  32'(spawn_type), 32'(hold_t));
            chk("bp_vel",   32'(spawn_vel),  32'(hold_v));
        end
        rand_in     = 8'h05;
        spawn_ready = 1'b1;
        cyc(1'b0, 1'b0);
        spawn_ready = 1'b0;
        chk("acc_valid", 32'(spawn_valid), 32'd0);
        chk("acc_count", 32'(active_count), 32'd1);

        // Capacity: ready held high, three more accepts then stall at 4
        spawn_ready = 1'b1;
        n_acc = 0;
        for (int i = 0; i < 200; i++) begin
            if (spawn_valid) n_acc++;
            cyc(1'b1, 1'b0);
        end
        spawn_ready = 1'b0;
        chk("cap_accepts", n_acc, 32'd3);
        chk("cap_count",   32'(active_count), 32'd4);
        chk("cap_valid",   32'(spawn_valid), 32'd0);
        cyc(1'b0, 1'b1);
        chk("free_count", 32'(active_count), 32'd3);
        chk("free_valid0", 32'(spawn_valid), 32'd0);
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        chk("free_valid2", 32'(spawn_valid), 32'd0);
        cyc(1'b0, 1'b0);
        chk("free_valid3", 32'(spawn_valid), 32'd1);
        chk("free_x",      32'(spawn_x),    32'd74);

        // Edge counts
        cyc(1'b0, 1'b1);
        chk("dsp_count", 32'(active_count), 32'd2);
        chk("dsp_valid", 32'(spawn_valid), 32'd1);
        spawn_ready = 1'b1;
        cyc(1'b0, 1'b1);
        spawn_ready = 1'b0;
        chk("accdsp_count", 32'(active_count), 32'd2);
        chk("accdsp_valid", 32'(spawn_valid), 32'd0);
        run_to_valid(100, "offer2_valid");
        enable = 1'b0;
        cyc(1'b0, 1'b0);
        chk("dis_valid", 32'(spawn_valid), 32'd0);
        chk("dis_count", 32'(active_count), 32'd2);
        chk("dis_x",     32'(spawn_x),    32'd74);
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b1);
        chk("dsp_to0", 32'(active_count), 32'd0);
        cyc(1'b0, 1'b1);
        chk("dsp_at0", 32'(active_count), 32'd0);

        // Async reset in OFFER with ready high: no accept counted
        enable = 1'b1;
        run_to_valid(100, "offer3_valid");
        spawn_ready = 1'b1;
        #2 reset = 1'b1;
        #1;
        chk("arst_valid", 32'(spawn_valid), 32'd0);
        chk("arst_x",     32'(spawn_x),    32'd0);
        chk("arst_type",  32'(spawn_type), 32'd0);
        chk("arst_vel",   32'(spawn_vel),  32'd0);
        chk("arst_count", 32'(active_count), 32'd0);
        @(posedge clk); #1;
        reset       = 1'b0;
        spawn_ready = 1'b0;
        chk("arst_rel_count", 32'(active_count), 32'd0);
        // From IDLE: reload, wait 21 ticks, then 3 edges to valid
        for (int i = 1; i <= 26; i++) begin
            cyc(1'b1, 1'b0);
            if (i == 25) chk("idle_lat25", 32'(spawn_valid), 32'd0);
            if (i == 26) chk("idle_lat26", 32'(spawn_valid), 32'd1);
        end

`ifdef SPAWN_DIFFICULTY_EN
        // level=2, rand 3F: gap (16>>2)+(63>>2)=19
        reset = 1'b1;
        @(posedge clk); #1;
        reset   = 1'b0;
        level   = 2'd2;
        rand_in = 8'h3F;
        for (int i = 1; i <= 24; i++) begin
            cyc(1'b1, 1'b0);
            if (i == 23) chk("lvl_lat23", 32'(spawn_valid), 32'd0);
            if (i == 24) chk("lvl_lat24", 32'(spawn_valid), 32'd1);
        end
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
